// File: rtl/refresh_maint_handler_pkg.sv
// Shared maintenance-path definitions: instruction field offsets, command builders, FSM states.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package refresh_maint_handler_pkg;

  localparam int VALID_BIT = 31;
  localparam int CS_OFS    = 27;
  localparam int RAS_OFS   = 26;
  localparam int CAS_OFS   = 25;
  localparam int WE_OFS    = 24;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_REQ       = 4'd1,
    ST_SCAN      = 4'd2,
    ST_ISSUE_PRE = 4'd3,
    ST_WAIT_RP   = 4'd4,
    ST_ISSUE_REF = 4'd5,
    ST_WAIT_RFC  = 4'd6,
`ifdef MAINT_REOPEN_EN
    ST_REOPEN    = 4'd7,
`endif
    ST_DONE      = 4'd8
  } state_t;

  // Generic builder: bank above the row field, CS forced to 0, strobes active-low.
  function automatic logic [31:0] mk_cmd(input logic ras_n, input logic cas_n, input logic we_n,
                                         input logic [31:0] bank, input logic [31:0] row,
                                         input int cs_w, input int row_w);
    logic [31:0] c;
    c = (bank << row_w) | row;
    c = c & ~(((32'd1 << cs_w) - 32'd1) << CS_OFS);
    c[VALID_BIT] = 1'b1;
    c[RAS_OFS]   = ras_n;
    c[CAS_OFS]   = cas_n;
    c[WE_OFS]    = we_n;
    return c;
  endfunction

  function automatic logic [31:0] mk_act(input logic [31:0] bank, input logic [31:0] row,
                                         input int cs_w, input int row_w);
    return mk_cmd(1'b0, 1'b1, 1'b1, bank, row, cs_w, row_w);
  endfunction

  function automatic logic [31:0] mk_pre(input logic [31:0] bank, input int cs_w, input int row_w);
    return mk_cmd(1'b0, 1'b1, 1'b0, bank, 32'd0, cs_w, row_w);
  endfunction

  function automatic logic [31:0] mk_ref(input int cs_w);
    return mk_cmd(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, cs_w, 0);
  endfunction

endpackage

// File: rtl/refresh_maint_handler_timer.sv
// Refresh interval timer with saturating postponed-refresh counter and sticky overflow flag.
// Latency: tick registered into pending_cnt on the following edge.
// Backpressure: none; ticks arriving at saturation are dropped and flagged via overflow.
module refresh_timer
  #(
    parameter int T_REFI      = 7800,
    parameter int MAX_PENDING = 8
  )
  (
    input  logic       clk,
    input  logic       rst,
    input  logic       dec,
    output logic [3:0] pending_cnt,
    output logic       overflow
  );

  localparam int TW = (T_REFI > 1) ? $clog2(T_REFI) : 1;

  logic [TW-1:0] tmr;
  logic          tick;

  assign tick = (tmr == TW'(T_REFI - 1));

  // Free-running interval counter; wrap is the refresh tick.
  always_ff @(posedge clk) begin
    if (rst) tmr <= '0;
    else     tmr <= tick ? '0 : tmr + TW'(1);
  end

  // Pending bookkeeping; a tick and a completion in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_cnt <= 4'd0;
      overflow    <= 1'b0;
    end else if (tick && !dec) begin
      if (pending_cnt == 4'(MAX_PENDING)) overflow <= 1'b1;
      else                                pending_cnt <= pending_cnt + 4'd1;
    end else if (dec && !tick) begin
      pending_cnt <= pending_cnt - 4'd1;
    end
  end

endmodule

// File: rtl/refresh_maint_handler.sv
// Auto-refresh maintenance: request bus, scan banks, PRE open banks, REF, optional re-open (MAINT_REOPEN_EN).
// Latency: all-banks-closed refresh = NUM_BANKS + 1 + T_RFC + 1 cycles from grant with ready high.
// Backpressure: instr/instr_valid held stable while instr_ready is low; FSM stalls in the issue state.
module refresh_maint_handler
  import refresh_maint_handler_pkg::*;
  #(
    parameter int ROW_WIDTH   = 16,
    parameter int BANK_WIDTH  = 3,
    parameter int CS_WIDTH    = 1,
    parameter int T_REFI      = 7800,
    parameter int T_RP        = 6,
    parameter int T_RFC       = 110,
    parameter int MAX_PENDING = 8
  )
  (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  maint_req,
    input  logic                  maint_gnt,
    output logic [BANK_WIDTH-1:0] maint_bank,
    input  logic [ROW_WIDTH:0]    maint_bank_state,
    output logic [31:0]           instr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [3:0]            pending_cnt,
    output logic                  overflow
  );

  localparam int NUM_BANKS = 1 << BANK_WIDTH;
  localparam logic [BANK_WIDTH-1:0] LAST_BANK = BANK_WIDTH'(NUM_BANKS - 1);
  localparam int WAIT_MAX = (T_RP > T_RFC) ? T_RP : T_RFC;
  localparam int WCW = $clog2(WAIT_MAX + 1);

  state_t                state_q, state_d;
  logic [BANK_WIDTH-1:0] bank_q, bank_d;
  logic                  pre_q, pre_d;
  logic [WCW-1:0]        wcnt;
  logic                  dec;
  logic                  open_now;

  assign open_now   = maint_bank_state[ROW_WIDTH];
  assign maint_bank = bank_q;
  assign maint_req  = !(state_q inside {ST_IDLE, ST_DONE});

  refresh_timer #(.T_REFI(T_REFI), .MAX_PENDING(MAX_PENDING)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .dec         (dec),
    .pending_cnt (pending_cnt),
    .overflow    (overflow)
  );

`ifdef MAINT_REOPEN_EN
  logic                 save_open [NUM_BANKS];
  logic [ROW_WIDTH-1:0] save_row  [NUM_BANKS];

  // Remember each bank's open/row state as it is scanned so it can be restored after REF.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        save_open[i] <= 1'b0;
        save_row[i]  <= '0;
      end
    end else if (state_q == ST_SCAN) begin
      save_open[bank_q] <= open_now;
      save_row[bank_q]  <= maint_bank_state[ROW_WIDTH-1:0];
    end
  end
`else
  // Without re-open only the open flag of the bank under scan matters.
  logic unused_row_bits;
  assign unused_row_bits = ^maint_bank_state[ROW_WIDTH-1:0];
`endif

  // State, bank pointer and PRE-issued flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bank_q  <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      pre_q   <= pre_d;
    end
  end

  // Shared wait counter for T_RP / T_RFC; restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst)                     wcnt <= '0;
    else if (state_d != state_q) wcnt <= '0;
    else                         wcnt <= wcnt + WCW'(1);
  end

  // Next-state, instruction and completion decode.
  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    pre_d       = pre_q;
    instr       = 32'd0;
    instr_valid = 1'b0;
    dec         = 1'b0;
    case (state_q)
      ST_IDLE: if (pending_cnt != 4'd0) state_d = ST_REQ;
      ST_REQ: begin
        if (maint_gnt) begin
          state_d = ST_SCAN;
          bank_d  = '0;
          pre_d   = 1'b0;
        end
      end
      ST_SCAN: begin
        if (open_now)                 state_d = ST_ISSUE_PRE;
        else if (bank_q == LAST_BANK) state_d = pre_q ? ST_WAIT_RP : ST_ISSUE_REF;
        else                          bank_d  = bank_q + BANK_WIDTH'(1);
      end
      ST_ISSUE_PRE: begin
        instr_valid = 1'b1;
        instr       = mk_pre(32'(bank_q), CS_WIDTH, ROW_WIDTH);
        if (instr_ready) begin
          pre_d = 1'b1;
          if (bank_q == LAST_BANK) state_d = ST_WAIT_RP;
          else begin
            bank_d  = bank_q + BANK_WIDTH'(1);
            state_d = ST_SCAN;
          end
        end
      end
      ST_WAIT_RP: if (wcnt == WCW'(T_RP - 1)) state_d = ST_ISSUE_REF;
      ST_ISSUE_REF: begin
        instr_valid = 1'b1;
        instr       = mk_ref(CS_WIDTH);
        if (instr_ready) state_d = ST_WAIT_RFC;
      end
      ST_WAIT_RFC: begin
        if (wcnt == WCW'(T_RFC - 1)) begin
          dec    = 1'b1;
          bank_d = '0;
`ifdef MAINT_REOPEN_EN
          state_d = ST_REOPEN;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef MAINT_REOPEN_EN
      ST_REOPEN: begin
        if (save_open[bank_q]) begin
          instr_valid = 1'b1;
          instr       = mk_act(32'(bank_q), 32'(save_row[bank_q]), CS_WIDTH, ROW_WIDTH);
        end
        if (!save_open[bank_q] || instr_ready) begin
          if (bank_q == LAST_BANK) state_d = ST_DONE;
          else                     bank_d  = bank_q + BANK_WIDTH'(1);
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
        bank_d  = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef SIM
  // The arbiter must hold the grant for the whole sequence once it has been given.
  gnt_held_a: assert property (@(posedge clk) disable iff (rst)
                               !(state_q inside {ST_IDLE, ST_REQ, ST_DONE}) |-> maint_gnt);
`endif

endmodule

// File: tb/tb_refresh_maint_handler.sv
// Directed bench for refresh_maint_handler with hand-computed cycle-exact expectations.
// Latency: n/a.
// Backpressure: instr_ready driven directly by the stimulus.
module tb_refresh_maint_handler;

  logic        clk;
  logic        rst;
  logic        maint_req;
  logic        maint_gnt;
  logic [2:0]  maint_bank;
  logic [16:0] maint_bank_state;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  pending_cnt;
  logic        overflow;

  logic        gnt_en;
  logic [7:0]  bank_open;
  logic [15:0] bank_row [8];

  typedef struct { int cyc; logic [31:0] ins; } xfer_t;
  xfer_t xq[$];

  int cyc;
  int n_vec;
  int n_miss;

  localparam logic [31:0] REF_I = 32'h8100_0000;

  refresh_maint_handler #(
    .ROW_WIDTH(16), .BANK_WIDTH(3), .CS_WIDTH(1),
    .T_REFI(100), .T_RP(6), .T_RFC(20), .MAX_PENDING(8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .maint_req        (maint_req),
    .maint_gnt        (maint_gnt),
    .maint_bank       (maint_bank),
    .maint_bank_state (maint_bank_state),
    .instr            (instr),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .pending_cnt      (pending_cnt),
    .overflow         (overflow)
  );

  assign maint_gnt        = maint_req & gnt_en;
  assign maint_bank_state = {bank_open[maint_bank], bank_row[maint_bank]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pre_i(input int b);
    return 32'h8200_0000 | (32'(b) << 16);
  endfunction

  function automatic logic [31:0] act_i(input int b, input logic [15:0] r);
    return 32'h8300_0000 | (32'(b) << 16) | 32'(r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Record a transfer for the upcoming edge, then move to the next cycle's negedge.
  task automatic step();
    if (instr_valid === 1'b1 && instr_ready === 1'b1) xq.push_back('{cyc: cyc, ins: instr});
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    gnt_en      = 1'b0;
    instr_ready = 1'b1;
    bank_open   = 8'h00;
    for (int i = 0; i < 8; i++) bank_row[i] = 16'h0000;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
    xq.delete();
  endtask

  int cnt;

  initial begin
    n_vec  = 0;
    n_miss = 0;
    cyc    = 0;

    // 1: all banks closed, single REF
    do_reset();
    gnt_en = 1'b1;
    chk("rst_req", maint_req, 1'b0);
    chk("rst_vld", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pend", pending_cnt, 4'd0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_bank", maint_bank, 3'd0);
    run_to(99);  chk("t1_pend99", pending_cnt, 4'd0);
    run_to(100); chk("t1_pend100", pending_cnt, 4'd1);
    chk("t1_req100", maint_req, 1'b0);
    run_to(101); chk("t1_req101", maint_req, 1'b1);
    run_to(104); chk("t1_scanbank", maint_bank, 3'd2);
    run_to(131); chk("t1_req_done", maint_req, 1'b0);
    chk("t1_pend_done", pending_cnt, 4'd0);
    run_to(140);
    chk("t1_nxfer", xq.size(), 1);
    if (xq.size() >= 1) begin
      chk("t1_ref", xq[0].ins, REF_I);
      chk("t1_refcyc", xq[0].cyc, 110);
    end

    // 2: banks 2 and 5 open
    do_reset();
    gnt_en = 1'b1;
    bank_open[2] = 1'b1; bank_row[2] = 16'h1234;
    bank_open[5] = 1'b1; bank_row[5] = 16'h00FF;
    run_to(170);
    begin
      logic [31:0] e_ins[$];
      int          e_cyc[$];
      e_ins.push_back(pre_i(2)); e_cyc.push_back(105);
      e_ins.push_back(pre_i(5)); e_cyc.push_back(109);
      e_ins.push_back(REF_I);    e_cyc.push_back(118);
`ifdef MAINT_REOPEN_EN
      e_ins.push_back(act_i(2, 16'h1234)); e_cyc.push_back(141);
      e_ins.push_back(act_i(5, 16'h00FF)); e_cyc.push_back(144);
`endif
      chk("t2_nxfer", xq.size(), e_ins.size());
      for (int k = 0; k < e_ins.size(); k++) begin
        if (k < xq.size()) begin
          chk("t2_ins", xq[k].ins, e_ins[k]);
          chk("t2_cyc", xq[k].cyc, e_cyc[k]);
        end
      end
    end
    chk("t2_pend", pending_cnt, 4'd0);

    // 3: PRE held under backpressure for 5 cycles
    do_reset();
    gnt_en = 1'b1;
    instr_ready = 1'b0;
    bank_open[2] = 1'b1; bank_row[2] = 16'hABCD;
    for (int c = 105; c <= 110; c++) begin
      run_to(c);
      chk("t3_vld", instr_valid, 1'b1);
      chk("t3_ins", instr, pre_i(2));
    end
    instr_ready = 1'b1;
    run_to(200);
    cnt = 0;
    foreach (xq[k]) if (xq[k].ins == pre_i(2)) cnt++;
    chk("t3_npre", cnt, 1);
    if (xq.size() >= 1) chk("t3_precyc", xq[0].cyc, 110);
    cnt = 0;
    foreach (xq[k]) if (xq[k].ins == REF_I) cnt++;
    chk("t3_nref", cnt, 1);

    // 4: grant withheld -> saturation, overflow, then back-to-back refreshes
    do_reset();
    run_to(700); chk("t4_pend700", pending_cnt, 4'd7);
    run_to(800); chk("t4_pend800", pending_cnt, 4'd8);
    chk("t4_ovf800", overflow, 1'b0);
    run_to(900); chk("t4_pend900", pending_cnt, 4'd8);
    chk("t4_ovf900", overflow, 1'b1);
    gnt_en = 1'b1;
    run_to(1200);
    for (int k = 0; k < 8; k++) begin
      if (k < xq.size()) begin
        chk("t4_ref", xq[k].ins, REF_I);
        chk("t4_refcyc", xq[k].cyc, 909 + 32 * k);
      end else begin
        chk("t4_missing_ref", 32'(xq.size()), 32'(k + 1));
      end
    end
    chk("t4_ovf_sticky", overflow, 1'b1);

    // 5: reset during WAIT_RFC
    do_reset();
    gnt_en = 1'b1;
    run_to(115);
    chk("t5_pend_pre", pending_cnt, 4'd1);
    chk("t5_req_pre", maint_req, 1'b1);
    rst = 1'b1;
    step();
    chk("t5_vld", instr_valid, 1'b0);
    chk("t5_req", maint_req, 1'b0);
    chk("t5_pend", pending_cnt, 4'd0);
    rst = 1'b0;
    repeat (10) step();
    chk("t5_idle_req", maint_req, 1'b0);

    // 6: tick coincides with completion at pending = 1
    do_reset();
    run_to(100); chk("t6_pend100", pending_cnt, 4'd1);
    run_to(101); chk("t6_req101", maint_req, 1'b1);
    run_to(170);
    gnt_en = 1'b1;
    run_to(198); chk("t6_pend198", pending_cnt, 4'd1);
    run_to(200); chk("t6_pend200", pending_cnt, 4'd1);
    chk("t6_req200", maint_req, 1'b0);
    run_to(201); chk("t6_req201", maint_req, 1'b0);
    run_to(202); chk("t6_req202", maint_req, 1'b1);
    run_to(240);
    chk("t6_nxfer", xq.size(), 2);
    if (xq.size() >= 2) begin
      chk("t6_ref0cyc", xq[0].cyc, 179);
      chk("t6_ref1cyc", xq[1].cyc, 211);
      chk("t6_ref1", xq[1].ins, REF_I);
    end
    chk("t6_pend_end", pending_cnt, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
